// File: rtl/sequence_generator_if.sv
// sequence_generator_if
//   Groups the request and serial-output signals of sequence_generator.
//   Optional build macro: SEQGEN_REPEAT_EN adds repeat_frame.
//
//   start        request one pattern (driven by master)
//   pattern      bits to send, MSB first (driven by master)
//   len          number of bits to send, 1..WIDTH (driven by master)
//   repeat_frame reload and resend without a gap (SEQGEN_REPEAT_EN only)
//   w            serial bit stream (driven by slave)
//   valid        w carries a pattern bit (driven by slave)
//   busy         transmission in progress (driven by slave)
//   done         one-cycle end-of-pattern pulse (driven by slave)
interface sequence_generator_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
`ifdef SEQGEN_REPEAT_EN
  logic             repeat_frame;
`endif
  logic             w;
  logic             valid;
  logic             busy;
  logic             done;

`ifdef SEQGEN_REPEAT_EN
  modport master (output start, pattern, len, repeat_frame,
                  input  w, valid, busy, done);
  modport slave  (input  start, pattern, len, repeat_frame,
                  output w, valid, busy, done);
`else
  modport master (output start, pattern, len,
                  input  w, valid, busy, done);
  modport slave  (input  start, pattern, len,
                  output w, valid, busy, done);
`endif
endinterface

// File: rtl/sequence_generator.sv
// sequence_generator
//   Serialises a captured pattern MSB first on w, feeding the
//   sequence-detector block. Optional build macro: SEQGEN_REPEAT_EN
//   (repeat_frame input plus a saved copy of pattern/len for gapless resend).
//
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    sequence_generator_if.slave (start/pattern/len in, w/valid/busy/done out)
//
//   state | meaning
//   IDLE  | waiting for start with 1 <= len <= WIDTH
//   SEND  | shifting bits out, one per cycle
//   DONE  | one-cycle done pulse, then back to IDLE
module sequence_generator #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  sequence_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] cnt;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             len_ok;
`ifdef SEQGEN_REPEAT_EN
  logic [WIDTH-1:0] saved_pat;
  logic [LEN_W-1:0] saved_len;
`endif

  assign len_ok = (bus.len != '0) && (bus.len <= WIDTH_L);

  // w is the shift-register MSB itself; the register is cleared on the way
  // into DONE so w is 0 whenever valid is 0.
  assign bus.w     = shreg[WIDTH-1];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQGEN_REPEAT_EN
      saved_pat <= '0;
      saved_len <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && len_ok) begin
            state     <= SEND;
            shreg     <= bus.pattern;
            cnt       <= bus.len;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
`ifdef SEQGEN_REPEAT_EN
            saved_pat <= bus.pattern;
            saved_len <= bus.len;
`endif
          end
        end
        SEND: begin
          if (cnt == ONE_L) begin
`ifdef SEQGEN_REPEAT_EN
            if (bus.repeat_frame) begin
              shreg <= saved_pat;
              cnt   <= saved_len;
            end else
`endif
            begin
              state   <= DONE;
              shreg   <= '0;
              cnt     <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt - ONE_L;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          shreg   <= '0;
          cnt     <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator
//   Directed bench for sequence_generator (WIDTH=8, LEN_W=4). Outputs are
//   compared as the nibble {w, valid, busy, done} 1 ns after each rising edge.
//   The repeat scenario is built only when SEQGEN_REPEAT_EN is defined.
module tb_sequence_generator;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  sequence_generator_if #(.WIDTH(8), .LEN_W(4)) bus ();

  sequence_generator #(.WIDTH(8), .LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.w, bus.valid, bus.busy, bus.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge; afterwards we sit in cycle N+1.
  task automatic launch(input logic [7:0] pat, input logic [3:0] n);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = n;
    step();
    bus.start   = 1'b0;
  endtask

  // From cycle N+1: expect n bits of exp_bits (MSB first), one done cycle, then idle.
  task automatic check_frame(input string tag, input logic [7:0] exp_bits, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s bit%0d", tag, i), 32'(outs()), 32'({exp_bits[7-i], 3'b110}));
      step();
    end
    check_eq($sformatf("%s done", tag), 32'(outs()), 32'b0011);
    step();
    check_eq($sformatf("%s idle", tag), 32'(outs()), 32'b0000);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
`ifdef SEQGEN_REPEAT_EN
    bus.repeat_frame = 1'b0;
`endif
    #1;
    check_eq("reset outs", 32'(outs()), 32'b0000);
    step();
    step();
    reset = 1'b1;

    // Quiet idle after reset release.
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("idle%0d", i), 32'(outs()), 32'b0000);
    end

    // 4-bit frame 1101.
    launch(8'b1101_0000, 4'd4);
    check_frame("len4", 8'b1101_0000, 4);

    // Invalid lengths are ignored.
    launch(8'hFF, 4'd0);
    check_eq("len0 a", 32'(outs()), 32'b0000);
    step();
    check_eq("len0 b", 32'(outs()), 32'b0000);
    launch(8'hFF, 4'd9);
    check_eq("len9 a", 32'(outs()), 32'b0000);
    step();
    check_eq("len9 b", 32'(outs()), 32'b0000);

    // Full-width frame.
    launch(8'hA5, 4'd8);
    check_frame("len8", 8'b1010_0101, 8);

    // Capture isolation and back-to-back with start held.
    bus.start   = 1'b1;
    bus.pattern = 8'b1110_0000;
    bus.len     = 4'd3;
    step();
    bus.pattern = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("hold bit%0d", i), 32'(outs()), 32'b1110);
      step();
    end
    check_eq("hold done", 32'(outs()), 32'b0011);
    step();
    check_eq("hold idle gap", 32'(outs()), 32'b0000);
    step();
    check_eq("hold 2nd bit0", 32'(outs()), 32'b0110);
    bus.start = 1'b0;
    step();
    check_eq("hold 2nd bit1", 32'(outs()), 32'b0110);
    step();
    check_eq("hold 2nd bit2", 32'(outs()), 32'b0110);
    step();
    check_eq("hold 2nd done", 32'(outs()), 32'b0011);
    step();
    check_eq("hold 2nd idle", 32'(outs()), 32'b0000);

    // Asynchronous reset in the middle of an 8-bit frame.
    launch(8'hFF, 4'd8);
    step();
    check_eq("abort bit1", 32'(outs()), 32'b1110);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort async", 32'(outs()), 32'b0000);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("abort quiet%0d", i), 32'(outs()), 32'b0000);
    end

    // First valid start after reset is accepted; single-bit frame.
    launch(8'b1000_0000, 4'd1);
    check_frame("len1", 8'b1000_0000, 1);

`ifdef SEQGEN_REPEAT_EN
    bus.repeat_frame = 1'b1;
    launch(8'b1100_0000, 4'd2);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("rep bit%0d", i), 32'(outs()), 32'b1110);
      if (i == 6) bus.repeat_frame = 1'b0;
      step();
    end
    check_eq("rep done", 32'(outs()), 32'b0011);
    step();
    check_eq("rep idle", 32'(outs()), 32'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter WIDTH, default 8: maximum pattern length in bits, and width of the pattern port.
REQ-002 Parameter LEN_W, default 4: width of the len port; it SHALL satisfy 2^LEN_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to transmit one pattern; sampled only in IDLE.
REQ-006 pattern  input  WIDTH  bits to send, MSB first; captured with start.
REQ-007 len  input  LEN_W  number of bits to send (1..WIDTH); captured with start.
REQ-008 w  output  1  serial bit stream, registered; drives the input of the sequence-detector block.
REQ-009 valid  output  1  high while w carries a pattern bit.
REQ-010 busy  output  1  high in SEND and DONE; low only in IDLE.
REQ-011 done  output  1  one-cycle pulse after the last bit of a pattern.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-013 In IDLE, an edge with start=1 and 1<=len<=WIDTH SHALL load the shift register with pattern, load the bit counter with len, and move the FSM to SEND.
REQ-014 In IDLE, start with len=0 or len>WIDTH SHALL be ignored: no state change and all outputs low.
REQ-015 In SEND:
- w = shift-register MSB, valid = 1.
- Each edge shifts the register left by one, zero-filled, and decrements the counter.
- When the counter equals 1, the same edge moves the FSM to DONE.
REQ-016 Latency: start sampled at edge N gives valid high in cycles N+1 .. N+len, done high in cycle N+len+1, and busy high in cycles N+1 .. N+len+1.
REQ-017 In DONE: done = 1, valid = 0, w = 0; the next edge moves the FSM to IDLE unconditionally.
REQ-018 start SHALL be ignored in SEND and DONE. A start held through DONE is accepted on the first IDLE edge, so the minimum gap between patterns is one DONE cycle plus one IDLE cycle.
REQ-019 Changes on pattern or len after capture SHALL NOT affect a transmission in progress.
REQ-020 w SHALL be 0 whenever valid = 0.
REQ-021 The counter SHALL be LEN_W bits wide and SHALL never wrap below 1 while in SEND.

Reset
REQ-022 Asserting reset low SHALL immediately, without a clock edge, force:
- the FSM to IDLE;
- the shift register, counter and saved pattern to 0;
- w, valid, busy and done to 0.
REQ-023 Reset asserted during SEND or DONE SHALL abort the transmission with no done pulse.
REQ-024 After reset deasserts, the first edge with start=1 and a valid len SHALL be accepted.

Configuration
REQ-025 Macro SEQGEN_REPEAT_EN.
REQ-026 When SEQGEN_REPEAT_EN is defined:
- Input port repeat (1 bit) is added, and a saved copy of pattern and len is kept.
- If repeat = 1 on the edge that would leave SEND, the shift register and counter reload from the saved copy and the FSM stays in SEND.
- The next pattern's first bit therefore follows the previous last bit with no gap and no done pulse.
- If repeat = 0 on that edge, the FSM proceeds to DONE as in REQ-015.
REQ-027 When SEQGEN_REPEAT_EN is undefined, the repeat port and the saved copy SHALL NOT exist, and behaviour SHALL be identical to the defined build with repeat tied to 0.

Verification
REQ-028 Reset low, then release; hold start=0 for 5 cycles -> w, valid, busy and done all 0 throughout.
REQ-029 WIDTH=8; start=1 for one cycle with pattern=8'b1101_0000 and len=4 at edge N -> w=1,1,0,1 with valid=1 in cycles N+1..N+4, done=1 only in N+5, busy=1 in N+1..N+5, then IDLE.
REQ-030 start with len=0, then with len=9 -> FSM stays IDLE and all outputs stay 0. start with len=8 and pattern=8'hA5 -> w=1,0,1,0,0,1,0,1.
REQ-031 Start len=3 pattern=8'b1110_0000, hold start=1 and change pattern to 8'h00 after capture -> first frame still sends 1,1,1. A second frame (all zeros) starts with valid rising in cycle N+6.
REQ-032 Assert reset low mid-SEND on the 2nd bit of an 8-bit frame -> outputs drop to 0 asynchronously and no done pulse follows.
REQ-033 With SEQGEN_REPEAT_EN, len=2, pattern=8'b1100_0000, repeat=1 for 3 frames then 0 -> w=1,1,1,1,1,1,1,1 over 8 contiguous valid cycles, followed by a single done pulse.
